tt_um_perceptron_connorguzi_core: RTL and testbench

TT_UM_PERCEPTRON_CONNORGUZI_CORE -- requirements
Module: tt_um_perceptron_connorguzi

---
 rtl/tt_um_perceptron_connorguzi_core.sv | 108 ++++++++++
 tb/tb_tt_um_perceptron_connorguzi_core.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/tt_um_perceptron_connorguzi_core.sv
// Binary-input perceptron: eight signed 4-bit weights plus bias, registered prediction on a 7-seg digit.
// Define PERCEPTRON_TRAIN_EN to build the perceptron-rule training update; without it mode 01 infers only.
module tt_um_perceptron_connorguzi_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        MODE_INFER = 2'b00,
        MODE_TRAIN = 2'b01,
        MODE_LOAD  = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    mode_e             mode;
    logic              t;
    logic              bias_sel;
    logic signed [3:0] load_data;
    logic        [2:0] load_addr;

    assign mode      = mode_e'(uio_in[1:0]);
    assign t         = uio_in[2];
    assign bias_sel  = uio_in[3];
    assign load_data = uio_in[7:4];
    assign load_addr = ui_in[2:0];

    logic signed [3:0] w_q [8];
    logic signed [3:0] w_d [8];
    logic signed [3:0] b_q, b_d;
    logic              y_q, y_d;

    // 8 bits hold the full range -72..+63, so the sign bit is the prediction.
    logic signed [7:0] sum;
    logic              p;

    always_comb begin
        sum = {{4{b_q[3]}}, b_q};
        for (int i = 0; i < 8; i++) begin
            if (ui_in[i]) sum = sum + {{4{w_q[i][3]}}, w_q[i]};
        end
    end

    assign p = ~sum[7];

`ifdef PERCEPTRON_TRAIN_EN
    function automatic logic signed [3:0] sat_step(input logic signed [3:0] v, input logic up);
        if (up) return (v == 4'sd7)  ? v : v + 4'sd1;
        else    return (v == -4'sd8) ? v : v - 4'sd1;
    endfunction
`else
    logic unused_target;
    assign unused_target = t;
`endif

    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_d = w_q;
        b_d = b_q;
        y_d = y_q;
        case (mode)
            MODE_INFER: y_d = p;
            MODE_TRAIN: begin
                y_d = p;
`ifdef PERCEPTRON_TRAIN_EN
                if (p != t) begin
                    for (int i = 0; i < 8; i++) begin
                        if (ui_in[i]) w_d[i] = sat_step(w_q[i], t);
                    end
                    b_d = sat_step(b_q, t);
                end
`endif
            end
            MODE_LOAD: begin
                if (bias_sel) b_d = load_data;
                else          w_d[load_addr] = load_data;
            end
            MODE_CLEAR: begin
                for (int i = 0; i < 8; i++) w_d[i] = '0;
                b_d = '0;
            end
        endcase
    end

    // NOTE: the weight array is reset like any other register; it is eight flops, not a RAM, and must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) w_q[i] <= '0;
            b_q <= '0;
            y_q <= 1'b0;
        end else if (ena) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            w_q <= w_d;
            b_q <= b_d;
            y_q <= y_d;
        end
    end

    assign uo_out  = {y_q, (y_q ? 7'h06 : 7'h3F)};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_perceptron_connorguzi_core.sv
// Directed self-checking bench for tt_um_perceptron_connorguzi_core; train checks follow PERCEPTRON_TRAIN_EN.
module tb_tt_um_perceptron_connorguzi_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] Y0 = 8'h3F;
    localparam logic [7:0] Y1 = 8'h86;

    tt_um_perceptron_connorguzi_core dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Drive between edges, clock once, sample 1 ns after the rising edge.
    task automatic cyc(input logic en, input logic [7:0] ui, input logic [7:0] uio);
        @(negedge clk);
        ena    = en;
        ui_in  = ui;
        uio_in = uio;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_uo", uo_out, Y0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #2;
        check("por_uo", uo_out, Y0);
        check("por_uio_out", uio_out, 8'h00);
        check("por_uio_oe", uio_oe, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero weights: s = 0 -> y = 1.
        cyc(1, 8'hFF, 8'h00);  check("infer_zero", uo_out, Y1);

        // Load b=-1 (y holds), infer -> 0; load w0=+3, infer x0 -> s=2.
        cyc(1, 8'h00, 8'hFA);  check("load_b_hold", uo_out, Y1);
        cyc(1, 8'h00, 8'h00);  check("infer_b_neg", uo_out, Y0);
        cyc(1, 8'h00, 8'h32);  check("load_w0_hold", uo_out, Y0);
        cyc(1, 8'h01, 8'h00);  check("infer_w0", uo_out, Y1);

        // Asynchronous reset between edges clears y and all weights.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_uo", uo_out, Y0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 8'h00, 8'h00);  check("post_rst_b0", uo_out, Y1);

        // ena=0 freezes state through clear and infer.
        cyc(1, 8'h03, 8'h52);                 // w3 = +5
        cyc(1, 8'h00, 8'hAA);                 // b = -6
        cyc(1, 8'h00, 8'h00);  check("infer_b_m6", uo_out, Y0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'h08, 8'h03);  check("ena0_clear_hold", uo_out, Y0);
        end
        cyc(1, 8'h08, 8'h00);  check("state_kept", uo_out, Y0);   // -6+5 = -1
        cyc(1, 8'h08, 8'h03);  check("clear_y_hold", uo_out, Y0);
        cyc(0, 8'h08, 8'h00);  check("ena0_infer_hold", uo_out, Y0);
        cyc(1, 8'h08, 8'h00);  check("after_clear", uo_out, Y1);
        cyc(1, 8'h00, 8'hEA);                 // b = -2
        cyc(1, 8'h08, 8'h00);  check("clear_b_m2", uo_out, Y0);

        // Address decode and signed extremes.
        do_reset();
        cyc(1, 8'h07, 8'h72);                 // w7 = +7
        cyc(1, 8'h06, 8'h82);                 // w6 = -8
        cyc(1, 8'h80, 8'h00);  check("w7_pos", uo_out, Y1);
        cyc(1, 8'h40, 8'h00);  check("w6_neg", uo_out, Y0);
        cyc(1, 8'hC0, 8'h00);  check("w67_sum_m1", uo_out, Y0);
        cyc(1, 8'h00, 8'h1A);                 // b = +1
        cyc(1, 8'hC0, 8'h00);  check("w67_b_sum0", uo_out, Y1);

        for (int i = 0; i < 8; i++) cyc(1, 8'(i), 8'h82);  // all w = -8
        cyc(1, 8'h00, 8'h8A);                               // b = -8
        cyc(1, 8'hFF, 8'h00);  check("sum_min_m72", uo_out, Y0);
        for (int i = 0; i < 8; i++) cyc(1, 8'(i), 8'h72);  // all w = +7
        cyc(1, 8'hFF, 8'h00);  check("sum_p48", uo_out, Y1);
        cyc(1, 8'h00, 8'h7A);                               // b = +7
        cyc(1, 8'h00, 8'h00);  check("b_max", uo_out, Y1);
        cyc(1, 8'hFF, 8'h00);  check("sum_max_p63", uo_out, Y1);

`ifdef PERCEPTRON_TRAIN_EN
        // Wrong prediction with t=0 decrements w0, w1, b.
        do_reset();
        cyc(1, 8'h03, 8'h01);  check("train_pre_pred", uo_out, Y1);
        cyc(1, 8'h03, 8'h00);  check("train_dec_sum", uo_out, Y0);
        cyc(1, 8'h00, 8'h00);  check("train_dec_b", uo_out, Y0);
        cyc(1, 8'h04, 8'h00);  check("train_w2_untouched", uo_out, Y0);

        // Saturation: w0 stays +7, b -8 -> -7.
        cyc(1, 8'h00, 8'h72);
        cyc(1, 8'h00, 8'h8A);
        cyc(1, 8'h01, 8'h05);  check("train_sat_pred", uo_out, Y0);
        cyc(1, 8'h01, 8'h00);  check("train_sat_sum0", uo_out, Y1);
        cyc(1, 8'h01, 8'h05);  check("train_agree", uo_out, Y1);
        cyc(1, 8'h00, 8'h00);  check("train_agree_b", uo_out, Y0);
`else
        // Mode 01 acts as infer: no update.
        do_reset();
        cyc(1, 8'h03, 8'h01);  check("mode01_pred", uo_out, Y1);
        cyc(1, 8'h03, 8'h00);  check("mode01_no_upd", uo_out, Y1);
        cyc(1, 8'h00, 8'h00);  check("mode01_b_zero", uo_out, Y1);
        cyc(1, 8'h00, 8'hFA);                 // b = -1
        cyc(1, 8'h00, 8'h05);  check("mode01_infer_neg", uo_out, Y0);
        cyc(1, 8'h00, 8'h00);  check("mode01_b_kept", uo_out, Y0);
`endif

        check("end_uio_out", uio_out, 8'h00);
        check("end_uio_oe", uio_oe, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
